alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_issue.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Single-issue front end for an external RV32 integer ALU. Accepts one
// instruction at a time, reads its source operands from a local 31 x 32-bit
// register file (x1..x31, x0 hard-wired to zero) and presents the decoded
// operation to the ALU. It then waits while the ALU reports busy, writes the
// result back and emits a one-cycle retire report.
//
// Optional feature (compile-time macro):
//   RV32M_ISSUE_EN  - when defined, register ops with funct7 = 0000001
//                     (the M extension, every funct3) are issued to the ALU.
//                     When undefined, they retire as illegal.
//
// Ports
//   clock              in   1   rising-edge clock for all state
//   reset_n            in   1   asynchronous active-low reset
//   instr              in   32  RV32 instruction word
//   instr_valid        in   1   instr present
//   instr_ready        out  1   accepting instr (transfer on valid && ready)
//   alu_is_op_alu      out  1   register-register op (opcode 0110011)
//   alu_is_op_alu_imm  out  1   register-immediate op (opcode 0010011)
//   alu_funct3         out  3   instr[14:12] of the op in flight
//   alu_funct7         out  7   instr[31:25] of the op in flight
//   alu_reg_s1         out  32  value of rs1
//   alu_reg_s2         out  32  value of rs2
//   alu_imm            out  32  sign-extended I immediate (0 for reg ops)
//   alu_rd             in   32  ALU result
//   alu_wait           in   1   ALU busy, combinational from the ALU inputs
//   retire_valid       out  1   one-cycle retire pulse
//   retire_rd          out  5   destination register of the retiring op
//   retire_data        out  32  result of the retiring op
//   retire_illegal     out  1   retiring op was illegal / unknown
//   dbg_addr           in   5   debug register-file read address
//   dbg_data           out  32  debug register-file read data (combinational)
// -----------------------------------------------------------------------------
module alu_issue (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic        alu_is_op_alu,
   output logic        alu_is_op_alu_imm,
   output logic [2:0]  alu_funct3,
   output logic [6:0]  alu_funct7,
   output logic [31:0] alu_reg_s1,
   output logic [31:0] alu_reg_s2,
   output logic [31:0] alu_imm,
   input  logic [31:0] alu_rd,
   input  logic        alu_wait,
   output logic        retire_valid,
   output logic [4:0]  retire_rd,
   output logic [31:0] retire_data,
   output logic        retire_illegal,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Operation captured at accept time; held unchanged for the whole EXEC stay.
   logic [31:0] instr_reg;
   logic [31:0] rs1_val_reg;
   logic [31:0] rs2_val_reg;
   logic        illegal_reg;

   logic              accept;
   logic              in_legal;
   logic              rf_we;
   logic [4:0]        rd_idx;
   logic [31:0][31:0] rf_word;

   assign rd_idx = instr_reg[11:7];

   // -------------------------------------------------------------------------
   // Legality of the incoming word, decided once at accept time so that EXEC
   // only has to look at a single flag.
   // -------------------------------------------------------------------------
   always_comb begin
      in_legal = 1'b0;
      case (instr[6:0])
         OPC_OP_IMM: begin
            // Only the shift encodings constrain the upper bits; for every
            // other funct3 those bits are just immediate bits.
            case (instr[14:12])
               3'd1:    in_legal = (instr[31:25] == F7_BASE);
               3'd5:    in_legal = (instr[31:25] == F7_BASE) ||
                                   (instr[31:25] == F7_ALT);
               default: in_legal = 1'b1;
            endcase
         end
         OPC_OP: begin
            case (instr[31:25])
               F7_BASE: in_legal = 1'b1;
               // sub and sra are the only alternate-encoding reg ops
               F7_ALT:  in_legal = (instr[14:12] == 3'd0) ||
                                   (instr[14:12] == 3'd5);
`ifdef RV32M_ISSUE_EN
               F7_MULDIV: in_legal = 1'b1;
`else
               F7_MULDIV: in_legal = 1'b0;
`endif
               default: in_legal = 1'b0;
            endcase
         end
         default: in_legal = 1'b0;
      endcase
   end

   // -------------------------------------------------------------------------
   // State register and captured operation
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instr_reg   <= '0;
         rs1_val_reg <= '0;
         rs2_val_reg <= '0;
         illegal_reg <= 1'b0;
      end else if (accept) begin
         // No write-back can happen in IDLE, so the operand read here can
         // never race a pending write to the same register.
         instr_reg   <= instr;
         rs1_val_reg <= rf_word[instr[19:15]];
         rs2_val_reg <= rf_word[instr[24:20]];
         illegal_reg <= !in_legal;
      end
   end

   // -------------------------------------------------------------------------
   // Next state and all outputs. Everything defaults to zero, which gives the
   // all-zero ALU bus in IDLE and zero retire fields when nothing retires.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next        = state_reg;
      instr_ready       = 1'b0;
      alu_is_op_alu     = 1'b0;
      alu_is_op_alu_imm = 1'b0;
      alu_funct3        = 3'd0;
      alu_funct7        = 7'd0;
      alu_reg_s1        = 32'd0;
      alu_reg_s2        = 32'd0;
      alu_imm           = 32'd0;
      retire_valid      = 1'b0;
      retire_rd         = 5'd0;
      retire_data       = 32'd0;
      retire_illegal    = 1'b0;
      rf_we             = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // Held low while reset is asserted, even though the state
            // register already reads IDLE.
            instr_ready = reset_n;
            if (instr_valid && reset_n) begin
               state_next = ST_EXEC;
            end
         end

         ST_EXEC: begin
            if (illegal_reg) begin
               // Illegal ops never reach the ALU and never wait on it.
               // retire_rd stays 0 because nothing is written.
               retire_valid   = 1'b1;
               retire_illegal = 1'b1;
               state_next     = ST_IDLE;
            end else begin
               alu_is_op_alu     = (instr_reg[6:0] == OPC_OP);
               alu_is_op_alu_imm = (instr_reg[6:0] == OPC_OP_IMM);
               alu_funct3        = instr_reg[14:12];
               alu_funct7        = instr_reg[31:25];
               alu_reg_s1        = rs1_val_reg;
               alu_reg_s2        = rs2_val_reg;
               if (instr_reg[6:0] == OPC_OP_IMM) begin
                  alu_imm = {{20{instr_reg[31]}}, instr_reg[31:20]};
               end
               if (!alu_wait) begin
                  retire_valid = 1'b1;
                  retire_rd    = rd_idx;
                  retire_data  = alu_rd;
                  rf_we        = (rd_idx != 5'd0);
                  state_next   = ST_IDLE;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign accept = instr_valid && instr_ready;

   // -------------------------------------------------------------------------
   // Register file: x0 is a constant zero, x1..x31 are individual words with
   // their own write decode. Asynchronous reset clears every word, so this
   // stays in fabric registers rather than block RAM.
   // -------------------------------------------------------------------------
   assign rf_word[0] = 32'd0;

   genvar gi;
   generate
      for (gi = 1; gi < 32; gi++) begin : g_rf
         logic [31:0] word_reg;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               word_reg <= '0;
            end else if (rf_we && (rd_idx == 5'(gi))) begin
               word_reg <= alu_rd;
            end
         end

         assign rf_word[gi] = word_reg;
      end
   endgenerate

   assign dbg_data = rf_word[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
//
// Drives alu_issue with directed and random RV32 ALU instructions while acting
// as the external ALU. A reference model (architectural register array plus
// the ISA legality rules) predicts every retire report and the ALU bus seen
// during each EXEC stay; predictions go into a queue that a separate monitor
// pops whenever the DUT retires. Honours RV32M_ISSUE_EN like the design.
// -----------------------------------------------------------------------------
module tb_alu_issue;

   logic        clock;
   logic        reset_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        alu_is_op_alu;
   logic        alu_is_op_alu_imm;
   logic [2:0]  alu_funct3;
   logic [6:0]  alu_funct7;
   logic [31:0] alu_reg_s1;
   logic [31:0] alu_reg_s2;
   logic [31:0] alu_imm;
   logic [31:0] alu_rd;
   logic        alu_wait;
   logic        retire_valid;
   logic [4:0]  retire_rd;
   logic [31:0] retire_data;
   logic        retire_illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   alu_issue dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .instr             (instr),
      .instr_valid       (instr_valid),
      .instr_ready       (instr_ready),
      .alu_is_op_alu     (alu_is_op_alu),
      .alu_is_op_alu_imm (alu_is_op_alu_imm),
      .alu_funct3        (alu_funct3),
      .alu_funct7        (alu_funct7),
      .alu_reg_s1        (alu_reg_s1),
      .alu_reg_s2        (alu_reg_s2),
      .alu_imm           (alu_imm),
      .alu_rd            (alu_rd),
      .alu_wait          (alu_wait),
      .retire_valid      (retire_valid),
      .retire_rd         (retire_rd),
      .retire_data       (retire_data),
      .retire_illegal    (retire_illegal),
      .dbg_addr          (dbg_addr),
      .dbg_data          (dbg_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        ill;
      int          cyc;
      logic        is_alu;
      logic        is_imm;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] imm;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] model_rf [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------------------------------------------------------- ALU model
   function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic is_imm, input logic [31:0] a,
                                            input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic [63:0]        p;
      logic [31:0]        r;
      sa = a;
      sb = b;
      r  = 32'd0;
      if (!is_imm && f7 == 7'h01) begin
         case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
         endcase
      end else begin
         case (f3)
            3'd0: r = (!is_imm && f7 == 7'h20) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'd0, sa < sb};
            3'd3: r = {31'd0, a < b};
            3'd4: r = a ^ b;
            3'd5: r = f7[5] ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
      return r;
   endfunction

   // The bench plays the ALU: result straight from the DUT's ALU bus.
   always_comb begin
      alu_rd = alu_calc(alu_funct3, alu_funct7, alu_is_op_alu_imm, alu_reg_s1,
                        alu_is_op_alu_imm ? alu_imm : alu_reg_s2);
   end

   // ISA legality rules for the instructions this issue stage handles.
   function automatic logic legal_of(input logic [31:0] ins);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      if (ins[6:0] == 7'h13) begin
         if (f3 == 3'd1) return f7 == 7'h00;
         if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
         return 1'b1;
      end
      if (ins[6:0] == 7'h33) begin
         if (f7 == 7'h00) return 1'b1;
         if (f7 == 7'h20) return f3 == 3'd0 || f3 == 3'd5;
`ifdef RV32M_ISSUE_EN
         if (f7 == 7'h01) return 1'b1;
`endif
         return 1'b0;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  op, f7;
      int          sel;
      r   = $urandom;
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? 7'h13 : (sel < 9) ? 7'h33 : 7'($urandom);
      case ($urandom_range(0, 4))
         1:       f7 = 7'h20;
         2:       f7 = 7'h01;
         3:       f7 = 7'($urandom);
         default: f7 = 7'h00;
      endcase
      return {f7, r[24:7], op};
   endfunction

   function automatic logic alu_any();
      return alu_is_op_alu | alu_is_op_alu_imm | (|alu_funct3) | (|alu_funct7) |
             (|alu_reg_s1) | (|alu_reg_s2) | (|alu_imm);
   endfunction

   // ------------------------------------------------------------------ driver
   // Handshake one instruction, record its predicted outcome and raise
   // alu_wait if the op is going to be held. Returns the effective wait count.
   task automatic accept(input logic [31:0] ins, input int w, output int w_eff);
      exp_t        e;
      logic        ok;
      logic [31:0] a, b;
      int          n;
      n = 0;
      @(negedge clock);
      while (!instr_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!instr_ready) check("accept_timeout", 32'(instr_ready), 32'd1);
      ok          = legal_of(ins);
      w_eff       = ok ? w : 0;
      instr       = ins;
      instr_valid = 1'b1;
      alu_wait    = 1'b0;
      @(posedge clock);
      #2;
      a        = model_rf[ins[19:15]];
      b        = model_rf[ins[24:20]];
      e.ill    = !ok;
      e.cyc    = cyc + w_eff;
      e.is_alu = ok && ins[6:0] == 7'h33;
      e.is_imm = ok && ins[6:0] == 7'h13;
      e.f3     = ok ? ins[14:12] : 3'd0;
      e.f7     = ok ? ins[31:25] : 7'd0;
      e.s1     = ok ? a : 32'd0;
      e.s2     = ok ? b : 32'd0;
      e.imm    = e.is_imm ? {{20{ins[31]}}, ins[31:20]} : 32'd0;
      if (ok) begin
         e.rd   = ins[11:7];
         e.data = alu_calc(ins[14:12], ins[31:25], e.is_imm, a, e.is_imm ? e.imm : b);
         if (ins[11:7] != 5'd0) model_rf[ins[11:7]] = e.data;
      end else begin
         e.rd   = 5'd0;
         e.data = 32'd0;
      end
      sbq.push_back(e);
      // Garbage on the input side while busy must be ignored.
      instr       = $urandom;
      instr_valid = (w_eff > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      alu_wait    = (w_eff > 0);
   endtask

   task automatic finish_wait(input int w);
      if (w > 0) begin
         repeat (w) @(posedge clock);
         #2;
         alu_wait    = 1'b0;
         instr_valid = 1'b0;
      end
   endtask

   task automatic issue(input logic [31:0] ins, input int w);
      int we;
      accept(ins, w, we);
      finish_wait(we);
   endtask

   // ----------------------------------------------------------------- monitor
   always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
         if (!retire_valid)
            check("retire_zero_when_idle",
                  {27'd0, retire_rd} | retire_data | {31'd0, retire_illegal}, 32'd0);
         if (instr_ready) begin
            check("idle_alu_zero", 32'(alu_any()), 32'd0);
            check("idle_no_retire", 32'(retire_valid), 32'd0);
         end else if (sbq.size() == 0) begin
            check("exec_without_issue", 32'(sbq.size()), 32'd1);
         end else begin
            e = sbq[0];
            check("alu_is_op_alu", 32'(alu_is_op_alu), 32'(e.is_alu));
            check("alu_is_op_alu_imm", 32'(alu_is_op_alu_imm), 32'(e.is_imm));
            check("alu_funct3", 32'(alu_funct3), 32'(e.f3));
            check("alu_funct7", 32'(alu_funct7), 32'(e.f7));
            check("alu_reg_s1", alu_reg_s1, e.s1);
            check("alu_reg_s2", alu_reg_s2, e.s2);
            check("alu_imm", alu_imm, e.imm);
            if (retire_valid) begin
               void'(sbq.pop_front());
               check("retire_rd", 32'(retire_rd), 32'(e.rd));
               check("retire_data", retire_data, e.data);
               check("retire_illegal", 32'(retire_illegal), 32'(e.ill));
               check("retire_cycle", 32'(cyc), 32'(e.cyc));
               $display("retire rd=%0d data=%h illegal=%0d cycle=%0d",
                        retire_rd, retire_data, retire_illegal, cyc);
            end
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      int          we;
      int          n;
      logic [31:0] ins;

      reset_n     = 1'b0;
      instr       = 32'd0;
      instr_valid = 1'b0;
      alu_wait    = 1'b0;
      dbg_addr    = 5'd0;
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_instr_ready", 32'(instr_ready), 32'd0);
      check("rst_retire_valid", 32'(retire_valid), 32'd0);
      check("rst_alu_zero", 32'(alu_any()), 32'd0);
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
      check("ready_after_reset", 32'(instr_ready), 32'd1);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1 check("rst_rf_zero", dbg_data, 32'd0);
      end

      // add x3,x1,x2 with x1=5, x2=7: retire T+1, ready again T+2
      issue(i_type(12'd5, 5'd0, 3'd0, 5'd1), 0);
      issue(i_type(12'd7, 5'd0, 3'd0, 5'd2), 0);
      accept(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 0, we);
      @(negedge clock);
      check("add_retire_t1", 32'(retire_valid), 32'd1);
      check("add_busy_t1", 32'(instr_ready), 32'd0);
      @(negedge clock);
      check("add_ready_t2", 32'(instr_ready), 32'd1);
      dbg_addr = 5'd3;
      #1 check("add_x3", dbg_data, 32'd12);

      // addi x0,x0,5: retires to x0, x0 still reads 0
      accept(i_type(12'd5, 5'd0, 3'd0, 5'd0), 0, we);
      @(negedge clock);
      check("x0_retire_valid", 32'(retire_valid), 32'd1);
      check("x0_retire_rd", 32'(retire_rd), 32'd0);
      @(negedge clock);
      dbg_addr = 5'd0;
      #1 check("x0_reads_zero", dbg_data, 32'd0);

      // mul x4,x7,x8 (6*7) held 8 cycles by alu_wait
      issue(i_type(12'd6, 5'd0, 3'd0, 5'd7), 0);
      issue(i_type(12'd7, 5'd0, 3'd0, 5'd8), 0);
      accept(r_type(7'h01, 5'd8, 5'd7, 3'd0, 5'd4), 8, we);
`ifdef RV32M_ISSUE_EN
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         check("mul_hold_funct7", 32'(alu_funct7), 32'h01);
         check("mul_hold_s1", alu_reg_s1, 32'd6);
         check("mul_hold_s2", alu_reg_s2, 32'd7);
         check("mul_hold_no_retire", 32'(retire_valid), 32'd0);
      end
      @(posedge clock);
      #2;
      alu_wait    = 1'b0;
      instr_valid = 1'b0;
      @(negedge clock);
      check("mul_retire_data", retire_data, 32'd42);
      @(negedge clock);
      check("mul_alu_zero_after", 32'(alu_any()), 32'd0);
      dbg_addr = 5'd4;
      #1 check("mul_x4", dbg_data, 32'd42);
`else
      @(negedge clock);
      check("m_illegal_flag", 32'(retire_illegal), 32'd1);
      check("m_illegal_data", retire_data, 32'd0);
      @(negedge clock);
      dbg_addr = 5'd4;
      #1 check("m_illegal_rd_unchanged", dbg_data, 32'd0);
`endif

      // srai x5,x6,4 with x6=0x80000000
      issue(i_type(12'd1, 5'd0, 3'd0, 5'd6), 0);
      issue(i_type(12'd31, 5'd6, 3'd1, 5'd6), 0);
      accept(i_type(12'h404, 5'd6, 3'd5, 5'd5), 0, we);
      @(negedge clock);
      check("srai_funct7", 32'(alu_funct7), 32'h20);
      check("srai_imm", alu_imm, 32'h0000_0404);
      check("srai_is_imm", 32'(alu_is_op_alu_imm), 32'd1);
      @(negedge clock);
      dbg_addr = 5'd5;
      #1 check("srai_x5", dbg_data, 32'hF800_0000);

      // Reset while an op is held by alu_wait
`ifdef RV32M_ISSUE_EN
      ins = r_type(7'h01, 5'd8, 5'd7, 3'd0, 5'd9);
`else
      ins = r_type(7'h00, 5'd8, 5'd7, 3'd0, 5'd9);
`endif
      accept(ins, 20, we);
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("abort_instr_ready", 32'(instr_ready), 32'd0);
      check("abort_retire_valid", 32'(retire_valid), 32'd0);
      check("abort_alu_zero", 32'(alu_any()), 32'd0);
      sbq.delete();
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      alu_wait    = 1'b0;
      instr_valid = 1'b0;
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
      check("abort_ready_after", 32'(instr_ready), 32'd1);
      dbg_addr = 5'd9;
      #1 check("abort_no_write", dbg_data, 32'd0);

      // Random traffic against the model
      for (int t = 0; t < 300; t++) begin
         issue(rand_instr(), $urandom_range(0, 3));
      end

      n = 0;
      while (sbq.size() > 0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("drain_empty", 32'(sbq.size()), 32'd0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1 check("final_rf", dbg_data, model_rf[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
